// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// This file holds the owner tag for the read return path, the default bus
// widths and the helper that sizes the starvation counter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 4;

    // Identifies which requester a pending read belongs to.
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    // Returns the number of bits needed to count from 0 up to max_burst inclusive.
    // The result is never less than 1, even for degenerate inputs.
    function automatic int cnt_width(input int max_burst);
        if (max_burst < 1) begin
            return 1;
        end
        return $clog2(max_burst + 1);
    endfunction

    // Counter width for the default burst limit.
    localparam int CNT_W = cnt_width(DEF_MAX_BURST);

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, the loader port and the memory-side signals.
// The slave modport is the arbiter's view.
// The master modport is the view of the surrounding SoC (core, loader and dmem).
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // core0 load/store port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // DMA / debug loader port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // single-port data memory
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating counter of back-to-back core grants won while the loader waits.
// A clear always wins over an increment.
// With neither clear nor inc asserted, the count holds.
module arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CTR_W     = cnt_width(MAX_BURST)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    localparam logic [CTR_W-1:0] MAX_CNT = CTR_W'(MAX_BURST);

    logic [CTR_W-1:0] cnt_d;
    logic [CTR_W-1:0] cnt_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between core0 and the DMA/debug loader.
// The core has priority. After MAX_BURST consecutive core wins against a
// waiting loader, the loader takes the next slot.
// Grants are combinational; read data returns exactly one cycle after the grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           system_ena,
    dmem_arbiter_if.slave  bus
);

    logic              active;
    logic              starve_at_max;
    logic              starve_clr;
    logic              starve_inc;
    logic              c_gnt_w;
    logic              d_gnt_w;
    logic              c_rvalid_w;
    logic              d_rvalid_w;
    logic              m_we_w;
    logic [ADDR_W-1:0] m_addr_w;
    logic [DATA_W-1:0] m_wdata_w;

    logic              rd_pend_d;
    logic              rd_pend_q;
    owner_t            rd_own_d;
    owner_t            rd_own_q;
    logic [DATA_W-1:0] c_rdata_d;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_d;
    logic [DATA_W-1:0] d_rdata_q;

    // Starvation counter; it only moves in cycles where arbitration actually happens.
    arb_starve_ctr #(
        .MAX_BURST (MAX_BURST)
    ) u_starve_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (starve_clr),
        .inc    (starve_inc),
        .at_max (starve_at_max)
    );

    // Arbitration: the core wins unless the loader has waited MAX_BURST core grants.
    // Grants are suppressed while disabled or in reset.
    always_comb begin
        active     = system_ena & ~reset;
        c_gnt_w    = active & bus.c_req & (~bus.d_req | ~starve_at_max);
        d_gnt_w    = active & bus.d_req & (~bus.c_req | starve_at_max);
        starve_clr = active & (~bus.d_req | d_gnt_w);
        starve_inc = active & bus.c_req & bus.d_req & ~starve_at_max;
    end

    // Memory command mux. When nothing is granted, the core inputs still drive addr/wdata.
    always_comb begin
        m_we_w    = 1'b0;
        m_addr_w  = bus.c_addr;
        m_wdata_w = bus.c_wdata;
        if (d_gnt_w) begin
            m_we_w    = bus.d_we;
            m_addr_w  = bus.d_addr;
            m_wdata_w = bus.d_wdata;
        end else if (c_gnt_w) begin
            m_we_w    = bus.c_we;
        end
    end

    // Read tracking and return path.
    // A granted read marks its owner for next cycle, and each port keeps its last returned word.
    always_comb begin
        rd_pend_d = (c_gnt_w & ~bus.c_we) | (d_gnt_w & ~bus.d_we);
        rd_own_d  = rd_own_q;
        if (d_gnt_w && !bus.d_we) begin
            rd_own_d = OWN_DMA;
        end else if (c_gnt_w && !bus.c_we) begin
            rd_own_d = OWN_CORE;
        end
        c_rvalid_w = rd_pend_q & (rd_own_q == OWN_CORE) & ~reset;
        d_rvalid_w = rd_pend_q & (rd_own_q == OWN_DMA) & ~reset;
        c_rdata_d  = c_rvalid_w ? bus.m_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_w ? bus.m_rdata : d_rdata_q;
    end

    // Pending-read flag, owner tag and held read data, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= OWN_CORE;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.c_gnt    = c_gnt_w;
        bus.d_gnt    = d_gnt_w;
        bus.c_rvalid = c_rvalid_w;
        bus.d_rvalid = d_rvalid_w;
        bus.c_rdata  = c_rdata_d;
        bus.d_rdata  = d_rdata_d;
        bus.m_en     = c_gnt_w | d_gnt_w;
        bus.m_we     = m_we_w;
        bus.m_addr   = m_addr_w;
        bus.m_wdata  = m_wdata_w;
    end

endmodule
